// File: rtl/parametric_scanout.sv
// Parametrised LCD timing generator and pixel scanout: counter -> stage 1 (handshake/flags)
// -> stage 2 (panel pins, underflow accounting). Two-cycle counter-to-pin latency.
module parametric_scanout #(
    parameter int unsigned BPC      = 8,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 1,
    parameter int unsigned H_BP     = 215,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 1,
    parameter int unsigned V_BP     = 34,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter logic [3*BPC-1:0] UNDERFLOW_COLOR = {{BPC{1'b1}}, {BPC{1'b0}}, {BPC{1'b1}}}
) (
    input  logic               in_clk,
    input  logic               in_reset_n,
    input  logic [3*BPC-1:0]   in_pixel_data,
    input  logic               in_pixel_valid,
    output logic               in_pixel_ready,
    input  logic [1:0]         in_mode,
    input  logic [3*BPC-1:0]   in_solid_color,
    input  logic               in_clear_underflow,
    output logic               out_next_frame,
    output logic               out_underflow,
    output logic [15:0]        out_underflow_count,
    output logic [BPC-1:0]     ltm_r,
    output logic [BPC-1:0]     ltm_g,
    output logic [BPC-1:0]     ltm_b,
    output logic               ltm_den,
    output logic               ltm_hd,
    output logic               ltm_vd
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW       = $clog2(H_TOTAL);
    localparam int unsigned YW       = $clog2(V_TOTAL);
    localparam int unsigned CW       = 3 * BPC;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_SOLID = 2'b01,
        MODE_BARS  = 2'b10,
        MODE_BLACK = 2'b11
    } mode_e;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    mode_e         mode_q;
    mode_e         mode_c;
    logic          active_c, drain_c, hs_c, vs_c, origin_c;
    logic [2:0]    bar_c;

    logic          s1_active, s1_hs, s1_vs;
    mode_e         s1_mode;
    logic [2:0]    s1_bar;

    logic [CW-1:0] pix_c;
    logic          uf_c;
    logic [15:0]   cnt_c;

    // Raster position; reset lands on the drain line so the FIFO empties first
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            x_q <= '0;
            y_q <= YW'(V_ACTIVE);
        end else if (32'(x_q) == H_TOTAL - 1) begin
            x_q <= '0;
            y_q <= (32'(y_q) == V_TOTAL - 1) ? '0 : y_q + YW'(1);
        end else begin
            x_q <= x_q + XW'(1);
        end
    end

    always_comb begin
        active_c = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
        drain_c  = (32'(y_q) == V_ACTIVE);
        hs_c     = (32'(x_q) >= HS_START) && (32'(x_q) < HS_END);
        vs_c     = (32'(y_q) >= VS_START) && (32'(y_q) < VS_END);
        origin_c = (x_q == '0) && (y_q == '0);
        mode_c   = origin_c ? mode_e'(in_mode) : mode_q;
        bar_c    = 3'((32'(x_q) * 32'd8) / H_ACTIVE);
    end

    // Mode only changes at the first pixel so a frame is never torn
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            mode_q <= MODE_PASS;
        end else if (origin_c) begin
            mode_q <= mode_e'(in_mode);
        end
    end

    // Stage 1: handshake and region flags
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            in_pixel_ready <= 1'b0;
            out_next_frame <= 1'b0;
            s1_active      <= 1'b0;
            s1_hs          <= 1'b0;
            s1_vs          <= 1'b0;
            s1_mode        <= MODE_PASS;
            s1_bar         <= '0;
        end else begin
            in_pixel_ready <= active_c || drain_c;
            out_next_frame <= drain_c;
            s1_active      <= active_c;
            s1_hs          <= hs_c;
            s1_vs          <= vs_c;
            s1_mode        <= mode_c;
            s1_bar         <= bar_c;
        end
    end

    // Pixel colour selection; bar index bits map directly to absent channels
    always_comb begin
        pix_c = '0;
        uf_c  = 1'b0;
        if (s1_active) begin
            case (s1_mode)
                MODE_PASS: begin
                    if (in_pixel_valid) begin
                        pix_c = in_pixel_data;
                    end else begin
                        pix_c = UNDERFLOW_COLOR;
                        uf_c  = in_pixel_ready;
                    end
                end
                MODE_SOLID: pix_c = in_solid_color;
                MODE_BARS:  pix_c = {{BPC{~s1_bar[0]}}, {BPC{~s1_bar[2]}}, {BPC{~s1_bar[1]}}};
                default:    pix_c = '0;
            endcase
        end
    end

    always_comb begin
        cnt_c = out_underflow_count;
        if (in_clear_underflow) begin
            cnt_c = '0;
        end else if (uf_c && (out_underflow_count != 16'hFFFF)) begin
            cnt_c = out_underflow_count + 16'd1;
        end
    end

    // Stage 2: all panel pins for one position update together
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            ltm_r               <= '0;
            ltm_g               <= '0;
            ltm_b               <= '0;
            ltm_den             <= 1'b0;
            ltm_hd              <= ~HS_POL;
            ltm_vd              <= ~VS_POL;
            out_underflow       <= 1'b0;
            out_underflow_count <= '0;
        end else begin
            ltm_r               <= pix_c[BPC-1:0];
            ltm_g               <= pix_c[2*BPC-1:BPC];
            ltm_b               <= pix_c[3*BPC-1:2*BPC];
            ltm_den             <= s1_active;
            ltm_hd              <= s1_hs ? HS_POL : ~HS_POL;
            ltm_vd              <= s1_vs ? VS_POL : ~VS_POL;
            out_underflow       <= uf_c;
            out_underflow_count <= cnt_c;
        end
    end

endmodule

// File: tb/tb_parametric_scanout.sv
// Directed bench for parametric_scanout on a reduced 25x8 raster (16x4 active).
module tb_parametric_scanout;

    localparam int unsigned BPC = 8;

    logic              in_clk;
    logic              in_reset_n;
    logic [3*BPC-1:0]  in_pixel_data;
    logic              in_pixel_valid;
    logic              in_pixel_ready;
    logic [1:0]        in_mode;
    logic [3*BPC-1:0]  in_solid_color;
    logic              in_clear_underflow;
    logic              out_next_frame;
    logic              out_underflow;
    logic [15:0]       out_underflow_count;
    logic [BPC-1:0]    ltm_r, ltm_g, ltm_b;
    logic              ltm_den, ltm_hd, ltm_vd;

    parametric_scanout #(
        .BPC(BPC), .H_ACTIVE(16), .H_FP(4), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut (
        .in_clk(in_clk), .in_reset_n(in_reset_n),
        .in_pixel_data(in_pixel_data), .in_pixel_valid(in_pixel_valid),
        .in_pixel_ready(in_pixel_ready), .in_mode(in_mode),
        .in_solid_color(in_solid_color), .in_clear_underflow(in_clear_underflow),
        .out_next_frame(out_next_frame), .out_underflow(out_underflow),
        .out_underflow_count(out_underflow_count),
        .ltm_r(ltm_r), .ltm_g(ltm_g), .ltm_b(ltm_b),
        .ltm_den(ltm_den), .ltm_hd(ltm_hd), .ltm_vd(ltm_vd)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    int n_vec, n_err, tk, word;
    int den_n, hd_n, vdl_n, nf_n, den_rise, hd_rise;
    bit acc_en;
    logic prev_den, prev_hd;
    logic [23:0] bars [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tk);
        end
    endtask

    function automatic logic [31:0] pins();
        return {8'h00, ltm_b, ltm_g, ltm_r};
    endfunction

    // One clock; handshake-driven counting data source and pin statistics
    task automatic tick();
        logic acc;
        acc = in_pixel_valid & in_pixel_ready;
        @(posedge in_clk);
        #1;
        tk++;
        if (acc === 1'b1) begin
            word++;
            in_pixel_data = 24'(word);
        end
        if (acc_en) begin
            den_n += ltm_den ? 1 : 0;
            hd_n  += ltm_hd ? 1 : 0;
            vdl_n += ltm_vd ? 0 : 1;
            nf_n  += out_next_frame ? 1 : 0;
        end
        if (den_rise < 0 && ltm_den && !prev_den) den_rise = tk;
        if (den_rise >= 0 && hd_rise < 0 && ltm_hd && !prev_hd) hd_rise = tk;
        prev_den = ltm_den;
        prev_hd  = ltm_hd;
    endtask

    task automatic run_to(input int t);
        while (tk < t) tick();
    endtask

    initial begin
        bars = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                 24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
        n_vec = 0; n_err = 0; tk = 0; word = 0;
        den_n = 0; hd_n = 0; vdl_n = 0; nf_n = 0;
        den_rise = -1; hd_rise = -1; acc_en = 1'b0;
        prev_den = 1'b0; prev_hd = 1'b0;
        in_reset_n = 1'b0; in_pixel_valid = 1'b1; in_pixel_data = '0;
        in_mode = 2'b00; in_solid_color = '0; in_clear_underflow = 1'b0;

        repeat (3) begin
            @(posedge in_clk);
            #1;
        end
        check("rst_ready", in_pixel_ready, 0);
        check("rst_next_frame", out_next_frame, 0);
        check("rst_underflow", out_underflow, 0);
        check("rst_count", out_underflow_count, 0);
        check("rst_den", ltm_den, 0);
        check("rst_hd", ltm_hd, 0);
        check("rst_vd", ltm_vd, 1);
        check("rst_rgb", pins(), 0);

        in_reset_n = 1'b1;
        tick();
        check("ready_after_release", in_pixel_ready, 1);
        check("next_frame_after_release", out_next_frame, 1);

        // First frame: passthrough with counting data, timing statistics
        run_to(2);
        acc_en = 1'b1;
        run_to(101);
        check("den_before_active", ltm_den, 0);
        check("ready_first_active", in_pixel_ready, 1);
        run_to(102);
        check("den_first_active", ltm_den, 1);
        check("first_pixel", pins(), 32'h19);
        run_to(117);
        check("last_pixel_line0", pins(), 32'h28);
        run_to(118);
        check("den_after_line0", ltm_den, 0);
        run_to(202);
        acc_en = 1'b0;
        check("den_clocks_per_frame", den_n, 64);
        check("hd_clocks_per_frame", hd_n, 16);
        check("vd_clocks_per_frame", vdl_n, 50);
        check("next_frame_clocks", nf_n, 25);
        check("den_rise_tick", den_rise, 102);
        check("hd_after_den", hd_rise - den_rise, 20);

        // Underflow: three starved pixels, then clear against a fourth
        run_to(304);
        check("uf_idle", out_underflow, 0);
        check("count_idle", out_underflow_count, 0);
        in_pixel_valid = 1'b0;
        run_to(305);
        check("uf_pix1", pins(), 32'hFF00FF);
        check("uf_pulse1", out_underflow, 1);
        check("uf_count1", out_underflow_count, 1);
        run_to(306);
        check("uf_pix2", pins(), 32'hFF00FF);
        check("uf_count2", out_underflow_count, 2);
        run_to(307);
        check("uf_pix3", pins(), 32'hFF00FF);
        check("uf_pulse3", out_underflow, 1);
        check("uf_count3", out_underflow_count, 3);
        in_pixel_valid = 1'b1;
        run_to(308);
        check("uf_pulse_end", out_underflow, 0);
        check("uf_count_hold", out_underflow_count, 3);
        check("den_mid_line", ltm_den, 1);
        run_to(310);
        in_pixel_valid = 1'b0;
        in_clear_underflow = 1'b1;
        run_to(311);
        check("clear_wins", out_underflow_count, 0);
        check("clear_pulse", out_underflow, 1);
        in_pixel_valid = 1'b1;
        in_clear_underflow = 1'b0;
        run_to(312);
        check("clear_hold", out_underflow_count, 0);

        // Mid-frame mode change stays passthrough until next frame
        run_to(320);
        in_mode = 2'b10;
        run_to(326);
        in_pixel_valid = 1'b0;
        check("ready_line1", in_pixel_ready, 1);
        run_to(327);
        check("mode_not_torn", pins(), 32'hFF00FF);
        check("mode_not_torn_den", ltm_den, 1);
        run_to(400);
        check("count_frame2", out_underflow_count, 48);
        run_to(500);
        check("ready_blank_bars", in_pixel_ready, 0);
        run_to(501);
        check("ready_active_bars", in_pixel_ready, 1);
        for (int x = 0; x < 16; x++) begin
            run_to(502 + x);
            check($sformatf("bar_x%0d", x), pins(), 32'(bars[x / 2]));
            check($sformatf("bar_uf_x%0d", x), out_underflow, 0);
        end

        // Solid then black frames
        run_to(530);
        in_mode = 2'b01;
        in_solid_color = 24'h123456;
        run_to(707);
        check("solid_pix", pins(), 32'h123456);
        check("solid_count", out_underflow_count, 48);
        run_to(718);
        check("solid_inactive", pins(), 0);
        check("solid_inactive_den", ltm_den, 0);
        run_to(720);
        in_mode = 2'b11;
        run_to(905);
        check("black_pix", pins(), 0);
        check("black_den", ltm_den, 1);

        // One-cycle reset mid-frame
        run_to(950);
        in_reset_n = 1'b0;
        @(posedge in_clk);
        #1;
        check("mid_rst_ready", in_pixel_ready, 0);
        check("mid_rst_den", ltm_den, 0);
        check("mid_rst_hd", ltm_hd, 0);
        check("mid_rst_vd", ltm_vd, 1);
        check("mid_rst_count", out_underflow_count, 0);
        check("mid_rst_nf", out_next_frame, 0);
        in_reset_n = 1'b1;
        in_pixel_valid = 1'b1;
        den_n = 0; nf_n = 0;
        acc_en = 1'b1;
        tick();
        check("mid_rst_nf_rise", out_next_frame, 1);
        check("mid_rst_ready_rise", in_pixel_ready, 1);
        repeat (39) tick();
        acc_en = 1'b0;
        check("mid_rst_nf_len", nf_n, 25);
        check("mid_rst_den_idle", den_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
